// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and register-index type for the multi-ported register file.
// The REG_FILE_BYPASS_EN macro (see reg_file_mp.sv) does not affect this package.
package reg_file_mp_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int PC_W_DEF     = 32;

    function automatic int addr_width(input int num_regs);
        return $clog2(num_regs);
    endfunction

    localparam int ADDR_W_DEF = addr_width(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Busy scoreboard: one bit per register, set on issue, cleared by writes,
// wiped by flush. Register 0 is never busy.
module reg_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ADDR_W   = addr_width(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     set_en_i,
    input  logic [ADDR_W-1:0]        set_addr_i,
    input  logic [NUM_WR-1:0]        clr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] clr_addr_i,
    input  logic                     flush_i,
    input  logic [NUM_RD*ADDR_W-1:0] lookup_addr_i,
    output logic [NUM_RD-1:0]        busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Order matters: clears first, then a new producer re-sets, then flush wins over all.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (clr_en_i[j]) begin
                busy_d[clr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            busy_o[i] = busy_q[lookup_addr_i[i*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file with busy scoreboard and exception capture (rm0/rm1).
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 1,
    parameter  int PC_W     = PC_W_DEF,
    localparam int ADDR_W   = addr_width(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_dest_i,
    input  logic                     flush_i,
    input  logic                     xcpt_valid_i,
    input  logic [PC_W-1:0]          xcpt_pc_i,
    input  logic [DATA_W-1:0]        xcpt_addr_i,
    output logic [PC_W-1:0]          rm0_o,
    output logic [DATA_W-1:0]        rm1_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [PC_W-1:0]   rm0_q, rm0_d;
    logic [DATA_W-1:0] rm1_q, rm1_d;
    logic [NUM_WR-1:0] wr_live;
    logic [NUM_RD-1:0] sb_busy;

    always_comb begin
        wr_live = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_live[j] = wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] != '0);
        end
    end

    // Ascending port order lets the highest-indexed port win a same-address collision.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_live[j]) begin
                regs_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = wr_data_i[j*DATA_W +: DATA_W];
            end
        end
        regs_d[0] = '0;
        rm0_d = xcpt_valid_i ? xcpt_pc_i   : rm0_q;
        rm1_d = xcpt_valid_i ? xcpt_addr_i : rm1_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            rm0_q <= '0;
            rm1_q <= '0;
        end else begin
            regs_q <= regs_d;
            rm0_q  <= rm0_d;
            rm1_q  <= rm1_d;
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .set_en_i      (iss_en_i && (iss_dest_i != '0)),
        .set_addr_i    (iss_dest_i),
        .clr_en_i      (wr_live),
        .clr_addr_i    (wr_addr_i),
        .flush_i       (flush_i),
        .lookup_addr_i (rd_addr_i),
        .busy_o        (sb_busy)
    );

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_o[i*DATA_W +: DATA_W] = regs_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
            rd_busy_o[i]                  = sb_busy[i];
`ifdef REG_FILE_BYPASS_EN
            // Gated by reset so outputs stay zero while reset is held.
            for (int j = 0; j < NUM_WR; j++) begin
                if (rst_ni && wr_live[j] &&
                    (wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i[i*ADDR_W +: ADDR_W])) begin
                    rd_data_o[i*DATA_W +: DATA_W] = wr_data_i[j*DATA_W +: DATA_W];
                    rd_busy_o[i]                  = 1'b0;
                end
            end
`endif
        end
    end

    assign rm0_o = rm0_q;
    assign rm1_o = rm1_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic
// against an array-based reference model.
module tb_reg_file_mp;

    localparam int NR  = 16;
    localparam int DW  = 32;
    localparam int NRD = 3;
    localparam int NWR = 2;
    localparam int PCW = 32;
    localparam int AW  = 4;

    logic              clk;
    logic              rst_n;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_dest;
    logic              flush;
    logic              xcpt_valid;
    logic [PCW-1:0]    xcpt_pc;
    logic [DW-1:0]     xcpt_addr;
    logic [PCW-1:0]    rm0;
    logic [DW-1:0]     rm1;

    logic [DW-1:0]  m_regs [NR];
    bit             m_busy [NR];
    logic [PCW-1:0] m_rm0;
    logic [DW-1:0]  m_rm1;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_mp #(
        .NUM_REGS (NR),
        .DATA_W   (DW),
        .NUM_RD   (NRD),
        .NUM_WR   (NWR),
        .PC_W     (PCW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .iss_en_i     (iss_en),
        .iss_dest_i   (iss_dest),
        .flush_i      (flush),
        .xcpt_valid_i (xcpt_valid),
        .xcpt_pc_i    (xcpt_pc),
        .xcpt_addr_i  (xcpt_addr),
        .rm0_o        (rm0),
        .rm1_o        (rm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        m_rm0 = '0;
        m_rm1 = '0;
    endtask

    task automatic set_idle();
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        iss_en     = 1'b0;
        iss_dest   = '0;
        flush      = 1'b0;
        xcpt_valid = 1'b0;
        xcpt_pc    = '0;
        xcpt_addr  = '0;
    endtask

    task automatic set_wr(input int port, input int addr, input logic [DW-1:0] data);
        wr_en[port]              = 1'b1;
        wr_addr[port*AW +: AW]   = AW'(addr);
        wr_data[port*DW +: DW]   = data;
    endtask

    task automatic set_rd(input int port, input int addr);
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    // Expected read for one address given the current (pre-edge) inputs.
    task automatic expect_read(input int a, output logic [DW-1:0] d, output bit b);
        d = m_regs[a];
        b = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
            if (rst_n && wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                d = wr_data[j*DW +: DW];
                b = 1'b0;
            end
        end
`endif
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [DW-1:0] d;
        bit            b;
        for (int i = 0; i < NRD; i++) begin
            expect_read(int'(rd_addr[i*AW +: AW]), d, b);
            check($sformatf("rd_data[%0d] r%0d", i, rd_addr[i*AW +: AW]), 64'(rd_data[i*DW +: DW]), 64'(d));
            check($sformatf("rd_busy[%0d] r%0d", i, rd_addr[i*AW +: AW]), 64'(rd_busy[i]), 64'(b));
        end
        check("rm0", 64'(rm0), 64'(m_rm0));
        check("rm1", 64'(rm1), 64'(m_rm1));
    endtask

    // Architectural effect of one clock edge, stated directly from the rules.
    task automatic model_edge();
        for (int j = 0; j < NWR; j++) begin
            int a = int'(wr_addr[j*AW +: AW]);
            if (wr_en[j] && a != 0) begin
                m_regs[a] = wr_data[j*DW +: DW];
                m_busy[a] = 1'b0;
            end
        end
        if (iss_en && iss_dest != 0) m_busy[iss_dest] = 1'b1;
        if (flush) begin
            for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
        end
        if (xcpt_valid) begin
            m_rm0 = xcpt_pc;
            m_rm1 = xcpt_addr;
        end
    endtask

    // Called just after a falling edge with inputs set: check, take the edge, return at next falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] old_r9;
        rst_n   = 1'b0;
        rd_addr = '0;
        set_idle();
        model_reset();
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Write r5 then read it back.
        set_wr(0, 5, 32'hDEADBEEF);
        cycle();
        set_idle();
        set_rd(0, 5);
        #1;
        check("r5_data", 64'(rd_data[DW-1:0]), 64'h0000_0000_DEAD_BEEF);
        check("r5_busy", 64'(rd_busy[0]), 64'h0);
        cycle();

        // Writes and issues to r0 are ignored.
        set_wr(0, 0, 32'h1234);
        iss_en   = 1'b1;
        iss_dest = '0;
        cycle();
        set_idle();
        set_rd(0, 0);
        #1;
        check("r0_data", 64'(rd_data[DW-1:0]), 64'h0);
        check("r0_busy", 64'(rd_busy[0]), 64'h0);
        cycle();

        // Two ports hit r7: port 1 wins.
        set_wr(0, 7, 32'h11);
        set_wr(1, 7, 32'h22);
        cycle();
        set_idle();
        set_rd(1, 7);
        #1;
        check("r7_collision", 64'(rd_data[DW +: DW]), 64'h22);
        cycle();

        // Busy: issue, write+issue keeps it busy, flush+issue clears it.
        iss_en = 1'b1; iss_dest = 3;
        cycle();
        set_idle();
        set_wr(0, 3, 32'h33);
        iss_en = 1'b1; iss_dest = 3;
        set_rd(2, 3);
        cycle();
        set_idle();
        #1;
        check("r3_busy_new_producer", 64'(rd_busy[2]), 64'h1);
        check("r3_data_written", 64'(rd_data[2*DW +: DW]), 64'h33);
        flush = 1'b1;
        iss_en = 1'b1; iss_dest = 3;
        cycle();
        set_idle();
        #1;
        check("r3_busy_after_flush", 64'(rd_busy[2]), 64'h0);
        cycle();

        // Same-cycle write and read of r9.
        set_wr(0, 9, 32'h77);
        cycle();
        set_idle();
        old_r9 = 32'h77;
        set_wr(0, 9, 32'hA5);
        set_rd(0, 9);
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("r9_rdw", 64'(rd_data[DW-1:0]), 64'hA5);
`else
        check("r9_rdw", 64'(rd_data[DW-1:0]), 64'(old_r9));
`endif
        cycle();
        set_idle();

        // Exception capture.
        xcpt_valid = 1'b1; xcpt_pc = 32'h400; xcpt_addr = 32'hBAD;
        cycle();
        set_idle();
        #1;
        check("rm0_capture", 64'(rm0), 64'h400);
        check("rm1_capture", 64'(rm1), 64'hBAD);
        cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            set_idle();
            for (int j = 0; j < NWR; j++) begin
                if ($urandom_range(0, 1) == 1) set_wr(j, $urandom_range(0, NR - 1), $urandom);
            end
            iss_en   = ($urandom_range(0, 1) == 1);
            iss_dest = AW'($urandom_range(0, NR - 1));
            flush    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                xcpt_valid = 1'b1;
                xcpt_pc    = $urandom;
                xcpt_addr  = $urandom;
            end
            for (int i = 0; i < NRD; i++) begin
                if ($urandom_range(0, 3) == 0) rd_addr[i*AW +: AW] = wr_addr[0 +: AW];
                else set_rd(i, $urandom_range(0, NR - 1));
            end
            cycle();
        end

        // Reset asserted mid-write: everything reads zero immediately.
        set_idle();
        set_wr(0, 5, 32'hCAFE);
        set_wr(1, 6, 32'hF00D);
        xcpt_valid = 1'b1; xcpt_pc = 32'h1; xcpt_addr = 32'h2;
        set_rd(0, 5); set_rd(1, 6); set_rd(2, 7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_rd_data", 64'(rd_data), 64'h0);
        check("rst_rd_busy", 64'(rd_busy), 64'h0);
        check("rst_rm0", 64'(rm0), 64'h0);
        check("rst_rm1", 64'(rm1), 64'h0);
        @(negedge clk);
        #1;
        check("rst_hold_rd_data", 64'(rd_data), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        cycle();
        // First write after deassertion lands.
        set_wr(0, 5, 32'hBEEF);
        cycle();
        set_idle();
        #1;
        check("post_rst_write", 64'(rd_data[DW-1:0]), 64'hBEEF);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
